dcache_dm_wt: RTL and testbench

//  Parametrised direct-mapped, write-through, no-write-allocate data cache between the MEM stage and a

---
 rtl/dcache_pkg.sv | 38 +++
 rtl/dcache_line_store.sv | 58 +++++
 rtl/dcache_dm_wt.sv | 260 ++++++++++++++++++++++++++
 tb/tb_dcache_dm_wt.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the direct-mapped write-through data cache.
//   state_e      - 2-bit FSM state encoding
//   off_w        - byte-offset field width (log2 of bytes per word)
//   word_w       - word-in-line field width (log2 of words per line)
//   idx_w        - line index field width (log2 of line count)
//   tag_w        - remaining upper address bits
//   at_least_1   - clamps a field width so it can size a vector
package dcache_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRefill  = 2'd1,
        StRespond = 2'd2,
        StWrite   = 2'd3
    } state_e;

    function automatic int unsigned off_w(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int unsigned word_w(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned idx_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned data_w,
                                          input int unsigned lines, input int unsigned line_words);
        return addr_w - off_w(data_w) - word_w(line_words) - idx_w(lines);
    endfunction

    function automatic int unsigned at_least_1(input int unsigned w);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// dcache_line_store: tag and data arrays of the direct-mapped cache.
//   clk_i          clock; all writes on posedge
//   w_idx_i        line index for tag and data writes
//   tag_we_i       write w_tag_i into the tag of line w_idx_i
//   w_tag_i        tag write value
//   data_we_i      write w_data_i into word w_word_i of line w_idx_i, byte-merged per w_be_i
//   w_word_i       word within line for the data write
//   w_data_i       data write value
//   w_be_i         per-byte write enables
//   r_idx_i        line index for the combinational read
//   r_word_i       word within line for the combinational read
//   r_tag_o        tag of line r_idx_i
//   r_data_o       word r_word_i of line r_idx_i
// No reset: contents are qualified by the valid bits held in the top level.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINES      = 1024,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned TAG_W      = 18,
    parameter int unsigned IDX_W      = 10,
    parameter int unsigned WORD_W     = 2
) (
    input  logic                clk_i,
    input  logic [IDX_W-1:0]    w_idx_i,
    input  logic                tag_we_i,
    input  logic [TAG_W-1:0]    w_tag_i,
    input  logic                data_we_i,
    input  logic [WORD_W-1:0]   w_word_i,
    input  logic [DATA_W-1:0]   w_data_i,
    input  logic [DATA_W/8-1:0] w_be_i,
    input  logic [IDX_W-1:0]    r_idx_i,
    input  logic [WORD_W-1:0]   r_word_i,
    output logic [TAG_W-1:0]    r_tag_o,
    output logic [DATA_W-1:0]   r_data_o
);

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES][LINE_WORDS];

    always_ff @(posedge clk_i) begin
        if (tag_we_i) begin
            tag_mem[w_idx_i] <= w_tag_i;
        end
        if (data_we_i) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (w_be_i[b]) begin
                    data_mem[w_idx_i][w_word_i][8*b +: 8] <= w_data_i[8*b +: 8];
                end
            end
        end
    end

    assign r_tag_o  = tag_mem[r_idx_i];
    assign r_data_o = data_mem[r_idx_i][r_word_i];

endmodule

// File: rtl/dcache_dm_wt.sv
// dcache_dm_wt: direct-mapped, write-through, no-write-allocate data cache with burst refill.
//   clk_i, reset_i           clock; asynchronous active-high reset
//   cpu_req_i .. cpu_flush_i CPU request (held stable until cpu_ready_o), flush in IDLE only
//   cpu_rdata_o, cpu_ready_o load data and one-cycle completion pulse
//   mem_req_o .. mem_be_o    backing-memory beat request, held until mem_ack_i
//   mem_ack_i, mem_rdata_i   beat completion and read data
// Optional build macro DCACHE_STATS_EN adds stat_hits_o / stat_misses_o (saturating load
// hit/miss counters, counted on load acceptance in IDLE).
module dcache_dm_wt
    import dcache_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINES      = 1024,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                cpu_req_i,
    input  logic                cpu_we_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]   cpu_wdata_i,
    input  logic [DATA_W/8-1:0] cpu_be_i,
    input  logic                cpu_flush_i,
    output logic [DATA_W-1:0]   cpu_rdata_o,
    output logic                cpu_ready_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]         stat_hits_o,
    output logic [31:0]         stat_misses_o
`endif
);

    localparam int unsigned Bytes  = DATA_W / 8;
    localparam int unsigned OffW   = off_w(DATA_W);
    localparam int unsigned WordW  = word_w(LINE_WORDS);
    localparam int unsigned IdxW   = idx_w(LINES);
    localparam int unsigned TagW   = tag_w(ADDR_W, DATA_W, LINES, LINE_WORDS);
    localparam int unsigned WordIW = at_least_1(WordW);
    localparam int unsigned IdxIW  = at_least_1(IdxW);

    state_e              state_q, state_d;
    logic [WordIW-1:0]   beat_q, beat_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic                cpu_ready_q, cpu_ready_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [Bytes-1:0]    mem_be_q, mem_be_d;

    // Address fields; the CPU address is held for the whole transaction.
    logic [WordIW-1:0]   req_word;
    logic [IdxIW-1:0]    req_idx;
    logic [TagW-1:0]     req_tag;
    logic [ADDR_W-1:0]   word_addr, line_base;

    assign req_word  = WordIW'((cpu_addr_i >> OffW) & ADDR_W'(LINE_WORDS - 1));
    assign req_idx   = IdxIW'((cpu_addr_i >> (OffW + WordW)) & ADDR_W'(LINES - 1));
    assign req_tag   = TagW'(cpu_addr_i >> (OffW + WordW + IdxW));
    assign word_addr = (cpu_addr_i >> OffW) << OffW;
    assign line_base = (cpu_addr_i >> (OffW + WordW)) << (OffW + WordW);

    logic                st_tag_we, st_data_we;
    logic [WordIW-1:0]   st_word;
    logic [DATA_W-1:0]   st_wdata;
    logic [Bytes-1:0]    st_be;
    logic [TagW-1:0]     rd_tag;
    logic [DATA_W-1:0]   rd_data;

    dcache_line_store #(
        .DATA_W     (DATA_W),
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TagW),
        .IDX_W      (IdxIW),
        .WORD_W     (WordIW)
    ) u_store (
        .clk_i     (clk_i),
        .w_idx_i   (req_idx),
        .tag_we_i  (st_tag_we),
        .w_tag_i   (req_tag),
        .data_we_i (st_data_we),
        .w_word_i  (st_word),
        .w_data_i  (st_wdata),
        .w_be_i    (st_be),
        .r_idx_i   (req_idx),
        .r_word_i  (req_word),
        .r_tag_o   (rd_tag),
        .r_data_o  (rd_data)
    );

    logic hit, accept, beat_last, mem_done;

    assign hit       = valid_q[req_idx] && (rd_tag == req_tag);
    // Not sampling in the ready cycle keeps cpu_ready from pulsing back to back.
    assign accept    = (state_q == StIdle) && !cpu_flush_i && cpu_req_i && !cpu_ready_q;
    assign beat_last = (beat_q == WordIW'(LINE_WORDS - 1));
    assign mem_done  = mem_req_q && mem_ack_i;

    // State register (and registered outputs)
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            valid_q     <= '0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            valid_q     <= valid_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (cpu_we_i)  state_d = StWrite;
                    else if (!hit) state_d = StRefill;
                end
            end
            StRefill:  if (mem_done && beat_last) state_d = StRespond;
            StRespond: state_d = StIdle;
            StWrite:   if (mem_done) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        beat_d      = beat_q;
        valid_d     = valid_q;
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        st_tag_we   = 1'b0;
        st_data_we  = 1'b0;
        st_word     = req_word;
        st_wdata    = cpu_wdata_i;
        st_be       = cpu_be_i;
        unique case (state_q)
            StIdle: begin
                if (cpu_flush_i) begin
                    valid_d = '0;
                end else if (accept) begin
                    if (cpu_we_i) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_addr;
                        mem_wdata_d = cpu_wdata_i;
                        mem_be_d    = cpu_be_i;
                        st_data_we  = hit;
                    end else if (hit) begin
                        cpu_ready_d = 1'b1;
                        cpu_rdata_d = rd_data;
                    end else begin
                        // Line is invalid until its last beat lands, so a partial line never hits.
                        beat_d           = '0;
                        valid_d[req_idx] = 1'b0;
                        st_tag_we        = 1'b1;
                    end
                end
            end
            StRefill: begin
                st_word  = beat_q;
                st_wdata = mem_rdata_i;
                st_be    = '1;
                if (!mem_req_q) begin
                    // Raising here also yields the one idle cycle between beats.
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = line_base | (ADDR_W'(beat_q) << OffW);
                end else if (mem_ack_i) begin
                    mem_req_d  = 1'b0;
                    st_data_we = 1'b1;
                    beat_d     = beat_q + 1'b1;
                    if (beat_last) valid_d[req_idx] = 1'b1;
                end
            end
            StRespond: begin
                cpu_ready_d = 1'b1;
                cpu_rdata_d = rd_data;
            end
            StWrite: begin
                if (mem_done) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    cpu_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign cpu_ready_o = cpu_ready_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] hits_q, hits_d, misses_q, misses_d;

    always_comb begin
        hits_d   = hits_q;
        misses_d = misses_q;
        if (accept && !cpu_we_i) begin
            if (hit) begin
                if (hits_q != '1) hits_d = hits_q + 32'd1;
            end else begin
                if (misses_q != '1) misses_d = misses_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    assign stat_hits_o   = hits_q;
    assign stat_misses_o = misses_q;
`endif

endmodule

// File: tb/tb_dcache_dm_wt.sv
// tb_dcache_dm_wt: directed-vector bench for dcache_dm_wt with a behavioural backing memory.
module tb_dcache_dm_wt;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_flush;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_be;
    logic        cpu_ready;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    dcache_dm_wt u_dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_be_i    (cpu_be),
        .cpu_flush_i (cpu_flush),
        .cpu_rdata_o (cpu_rdata),
        .cpu_ready_o (cpu_ready),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_be_o    (mem_be),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hits_o   (stat_hits),
        .stat_misses_o (stat_misses)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Backing memory: 4096 words, one beat logged per real (mem_req high) ack.
    logic [31:0] mem [4096];
    logic [31:0] log_addr[$];
    logic [31:0] log_wdata[$];
    logic [3:0]  log_be[$];
    logic        log_we[$];
    int          ack_delay = 0;
    logic        spurious  = 1'b0;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 | (i << 2);
        mem[12'h040] = 32'h0000_00A0;
        mem[12'h041] = 32'h0000_00A1;
        mem[12'h042] = 32'h0000_00A2;
        mem[12'h043] = 32'h0000_00A3;
    end

    initial begin
        int          wait_cnt;
        logic [11:0] widx;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (reset) begin
                wait_cnt = 0;
            end else if (mem_req) begin
                if (wait_cnt < ack_delay) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    widx     = mem_addr[13:2];
                    mem_ack  = 1'b1;
                    mem_rdata = mem[widx];
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_be[b]) mem[widx][8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                    log_addr.push_back(mem_addr);
                    log_wdata.push_back(mem_wdata);
                    log_be.push_back(mem_be);
                    log_we.push_back(mem_we);
                end
            end else begin
                wait_cnt = 0;
                if (spurious) begin
                    mem_ack   = 1'b1;
                    mem_rdata = 32'hBAD0_BAD0;
                end
            end
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_wdata.delete();
        log_be.delete();
        log_we.delete();
    endtask

    // One CPU transaction; optionally holds cpu_flush high together with the request for its
    // first cycle. Returns load data and cycles from the accepting request to cpu_ready.
    task automatic cpu_op(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input logic flush_first,
                          output logic [31:0] rdata, output int cycles);
        @(posedge clk);
        #1;
        clear_log();
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_be    = be;
        cpu_flush = flush_first;
        if (flush_first) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_req_ignored_in_flush"}, {31'd0, cpu_ready}, 32'd0);
            check_eq({tag, "_no_mem_in_flush"}, {31'd0, mem_req}, 32'd0);
            cpu_flush = 1'b0;
        end
        cycles = 0;
        while (!cpu_ready && cycles < 300) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_eq({tag, "_ready"}, {31'd0, cpu_ready}, 32'd1);
        rdata   = cpu_rdata;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    task automatic check_refill(input string tag, input logic [31:0] base);
        check_eq({tag, "_beats"}, log_addr.size(), 32'd4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            check_eq($sformatf("%s_beat%0d_addr", tag, i), log_addr[i], base + 32'(i * 4));
            check_eq($sformatf("%s_beat%0d_we", tag, i), {31'd0, log_we[i]}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          cyc;
        int          k;
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_flush = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_be    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        check_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
        check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_mem_be", {28'd0, mem_be}, 32'd0);
        reset = 1'b0;

        // 1: cold miss refills the line in order
        cpu_op("t1", 1'b0, 32'h0000_0100, 32'd0, 4'h0, 1'b0, rd, cyc);
        check_eq("t1_rdata", rd, 32'h0000_00A0);
        check_refill("t1", 32'h0000_0100);

        // 2: hit, single-cycle latency, no memory traffic
        cpu_op("t2", 1'b0, 32'h0000_0108, 32'd0, 4'h0, 1'b0, rd, cyc);
        check_eq("t2_rdata", rd, 32'h0000_00A2);
        check_eq("t2_latency", cyc, 32'd1);
        check_eq("t2_no_mem", log_addr.size(), 32'd0);

        // 6: flush with a simultaneous request, then the same load misses
        cpu_op("t6", 1'b0, 32'h0000_0100, 32'd0, 4'h0, 1'b1, rd, cyc);
        check_eq("t6_rdata", rd, 32'h0000_00A0);
        check_refill("t6", 32'h0000_0100);
`ifdef DCACHE_STATS_EN
        check_eq("t6_stat_hits", stat_hits, 32'd1);
        check_eq("t6_stat_misses", stat_misses, 32'd2);
`endif

        // 3: partial store hit writes through and merges into the cached word
        cpu_op("t3st", 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'b0011, 1'b0, rd, cyc);
        check_eq("t3_beats", log_addr.size(), 32'd1);
        if (log_addr.size() > 0) begin
            check_eq("t3_addr", log_addr[0], 32'h0000_0104);
            check_eq("t3_we", {31'd0, log_we[0]}, 32'd1);
            check_eq("t3_be", {28'd0, log_be[0]}, 32'h0000_0003);
            check_eq("t3_wdata", log_wdata[0], 32'hDEAD_BEEF);
        end
        cpu_op("t3ld", 1'b0, 32'h0000_0104, 32'd0, 4'h0, 1'b0, rd, cyc);
        check_eq("t3_rdata", rd, 32'h0000_BEEF);
        check_eq("t3_hit_latency", cyc, 32'd1);
        check_eq("t3_hit_no_mem", log_addr.size(), 32'd0);

        // 4: store miss goes to memory only; later load still misses
        cpu_op("t4st", 1'b1, 32'h0000_2000, 32'h1234_5678, 4'b1111, 1'b0, rd, cyc);
        check_eq("t4_beats", log_addr.size(), 32'd1);
        if (log_addr.size() > 0) begin
            check_eq("t4_addr", log_addr[0], 32'h0000_2000);
            check_eq("t4_we", {31'd0, log_we[0]}, 32'd1);
        end
        cpu_op("t4ld", 1'b0, 32'h0000_2000, 32'd0, 4'h0, 1'b0, rd, cyc);
        check_eq("t4_rdata", rd, 32'h1234_5678);
        check_refill("t4", 32'h0000_2000);

        // 5: reset mid-refill with slow, noisy memory; reload must refill fully
        ack_delay = 3;
        spurious  = 1'b1;
        @(posedge clk);
        #1;
        clear_log();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0200;
        k = 0;
        while (log_addr.size() < 2 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("t5_two_beats_before_reset", log_addr.size(), 32'd2);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        cpu_req = 1'b0;
        #1;
        check_eq("t5_rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("t5_rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cpu_op("t5ld", 1'b0, 32'h0000_0200, 32'd0, 4'h0, 1'b0, rd, cyc);
        check_eq("t5_rdata", rd, 32'h1000_0200);
        check_refill("t5", 32'h0000_0200);
        cpu_op("t5hit", 1'b0, 32'h0000_020C, 32'd0, 4'h0, 1'b0, rd, cyc);
        check_eq("t5_hit_rdata", rd, 32'h1000_020C);
        check_eq("t5_hit_latency", cyc, 32'd1);
        spurious  = 1'b0;
        ack_delay = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
